// File: rtl/pwm_sample_sequencer_if.sv
// Sample stream from the tone/ROM source into the PWM sample sequencer.
// Valid/ready handshake carrying one 5-bit audio sample per transfer.
interface pwm_sample_sequencer_if;
    logic [4:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/pwm_sample_sequencer.sv
// Buffers 5-bit audio samples in a small FIFO and reloads the PWM duty reference
// only at PWM frame boundaries; primes before playback and counts underruns.
//
// state | meaning
// IDLE  | disabled, pwm_ref parked at IDLE_LEVEL, FIFO still accepts samples
// PRIME | enabled, waiting for PRIME_LEVEL samples before starting a frame
// PLAY  | counting ticks, loading a new sample at each frame boundary
module pwm_sample_sequencer #(
    parameter int         DEPTH       = 8,
    parameter int         PRIME_LEVEL = 4,
    parameter int         FRAME_TICKS = 32,
    parameter logic [4:0] IDLE_LEVEL  = 5'd0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         tick,
    pwm_sample_sequencer_if.slave        smp,
    output logic [4:0]                   pwm_ref,
    output logic                         frame_start,
    output logic                         playing,
    output logic                         underrun,
    output logic [7:0]                   underrun_cnt,
    output logic [$clog2(DEPTH):0]       level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
    localparam logic [LW-1:0] PRIME_L   = LW'(PRIME_LEVEL);
    localparam logic [FW-1:0] FRAME_END = FW'(FRAME_TICKS - 1);

    typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;

    state_t          state, state_next;
    logic [4:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [FW-1:0]   frame_cnt, frame_cnt_next;
    logic [4:0]      ref_next;
    logic            fs_next, ur_next;
    logic            push, pop, flush;
    logic [LW-1:0]   level_next;

    assign smp.s_ready = (level < DEPTH_L);

    // Disable flushes the FIFO, so any write landing in that same cycle is dropped.
    assign flush = (state != IDLE) && !enable;
    assign push  = smp.s_valid && smp.s_ready && !flush;

    always_comb begin
        state_next     = state;
        frame_cnt_next = frame_cnt;
        ref_next       = pwm_ref;
        fs_next        = 1'b0;
        ur_next        = 1'b0;
        pop            = 1'b0;
        case (state)
            IDLE: begin
                ref_next       = IDLE_LEVEL;
                frame_cnt_next = '0;
                if (enable) state_next = PRIME;
            end
            PRIME: begin
                ref_next       = IDLE_LEVEL;
                frame_cnt_next = '0;
                if (!enable) begin
                    state_next = IDLE;
                end else if (level >= PRIME_L) begin
                    state_next = PLAY;
                    pop        = 1'b1;
                    ref_next   = mem[rd_ptr];
                    fs_next    = 1'b1;
                end
            end
            PLAY: begin
                if (!enable) begin
                    state_next     = IDLE;
                    ref_next       = IDLE_LEVEL;
                    frame_cnt_next = '0;
                end else if (tick) begin
                    if (frame_cnt == FRAME_END) begin
                        frame_cnt_next = '0;
                        fs_next        = 1'b1;
                        if (level != '0) begin
                            pop      = 1'b1;
                            ref_next = mem[rd_ptr];
                        end else begin
                            ref_next   = IDLE_LEVEL;
                            ur_next    = 1'b1;
                            state_next = PRIME;
                        end
                    end else begin
                        frame_cnt_next = frame_cnt + FW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                ref_next   = IDLE_LEVEL;
            end
        endcase
    end

    always_comb begin
        level_next = level;
        if (flush)
            level_next = '0;
        else
            level_next = level + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            frame_cnt    <= '0;
            pwm_ref      <= IDLE_LEVEL;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
            playing      <= 1'b0;
            level        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            state       <= state_next;
            frame_cnt   <= frame_cnt_next;
            pwm_ref     <= ref_next;
            frame_start <= fs_next;
            underrun    <= ur_next;
            playing     <= (state_next == PLAY);
            level       <= level_next;
            if (ur_next && underrun_cnt != 8'hFF)
                underrun_cnt <= underrun_cnt + 8'd1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= smp.s_data;
    end
endmodule

// File: tb/tb_pwm_sample_sequencer.sv
// Directed bench for pwm_sample_sequencer: playback, underrun, backpressure,
// push/pop at a boundary, disable mid-frame and asynchronous reset.
module tb_pwm_sample_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       tick;
    logic [4:0] pwm_ref;
    logic       frame_start;
    logic       playing;
    logic       underrun;
    logic [7:0] underrun_cnt;
    logic [3:0] level;

    int n_checks = 0;
    int n_err    = 0;
    int fs_seen  = 0;
    int ur_seen  = 0;

    pwm_sample_sequencer_if smp ();

    pwm_sample_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .tick         (tick),
        .smp          (smp.slave),
        .pwm_ref      (pwm_ref),
        .frame_start  (frame_start),
        .playing      (playing),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .level        (level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_start) fs_seen++;
        if (underrun)    ur_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            repeat (3) cyc();
        end
    endtask

    task automatic boundary();
        ticks(31);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic write(input logic [4:0] d);
        smp.s_valid = 1'b1;
        smp.s_data  = d;
        cyc();
        smp.s_valid = 1'b0;
    endtask

    initial begin
        logic [4:0] seq [4];
        seq[0] = 5'd3; seq[1] = 5'd7; seq[2] = 5'd15; seq[3] = 5'd31;

        reset = 1'b1; enable = 1'b0; tick = 1'b0;
        smp.s_valid = 1'b0; smp.s_data = '0;
        #3;
        check("rst_pwm_ref", pwm_ref, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_playing", playing, 0);
        check("rst_underrun", underrun, 0);
        check("rst_underrun_cnt", underrun_cnt, 0);
        check("rst_level", level, 0);
        check("rst_s_ready", smp.s_ready, 1);
        cyc(); cyc();
        reset = 1'b0;
        cyc();

        // basic playback
        enable = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) write(seq[i]);
        check("prime_level", level, 4);
        check("prime_not_playing", playing, 0);
        cyc();
        check("play_entry_playing", playing, 1);
        check("play_entry_ref", pwm_ref, 3);
        check("play_entry_fs", frame_start, 1);
        check("play_entry_level", level, 3);
        for (int i = 1; i < 4; i++) begin
            ticks(31);
            check("mid_frame_ref", pwm_ref, seq[i-1]);
            check("mid_frame_fs", frame_start, 0);
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            check("boundary_ref", pwm_ref, seq[i]);
            check("boundary_fs", frame_start, 1);
            check("boundary_level", level, 3 - i);
        end
        cyc();
        check("fs_count_basic", fs_seen, 4);

        // underrun
        boundary();
        check("ur_ref", pwm_ref, 0);
        check("ur_pulse", underrun, 1);
        check("ur_fs", frame_start, 1);
        check("ur_cnt", underrun_cnt, 1);
        check("ur_playing", playing, 0);
        cyc();
        check("ur_pulse_end", underrun, 0);
        check("ur_pulse_count", ur_seen, 1);

        // restart from PRIME
        write(5'd1); write(5'd2); write(5'd3); write(5'd4);
        cyc();
        check("restart_playing", playing, 1);
        check("restart_ref", pwm_ref, 1);
        write(5'd5); write(5'd6);
        check("pre_pushpop_level", level, 5);

        // push and pop in the same cycle at a boundary
        ticks(31);
        tick = 1'b1; smp.s_valid = 1'b1; smp.s_data = 5'd9;
        cyc();
        tick = 1'b0; smp.s_valid = 1'b0;
        check("pushpop_level", level, 5);
        check("pushpop_ref", pwm_ref, 2);
        boundary();
        check("order_ref_3", pwm_ref, 3);
        boundary();
        check("order_ref_4", pwm_ref, 4);
        check("order_level", level, 3);

        // disable mid-frame, with a coincident write that must be dropped
        ticks(10);
        enable = 1'b0; smp.s_valid = 1'b1; smp.s_data = 5'd20;
        cyc();
        smp.s_valid = 1'b0;
        check("dis_playing", playing, 0);
        check("dis_ref", pwm_ref, 0);
        check("dis_level", level, 0);
        ticks(40);
        check("idle_ticks_ref", pwm_ref, 0);
        check("idle_ticks_fs_count", fs_seen, 9);
        check("idle_ur_cnt_kept", underrun_cnt, 1);

        // backpressure while idle
        for (int i = 0; i < 8; i++) begin
            check("bp_ready_before", smp.s_ready, 1);
            smp.s_valid = 1'b1; smp.s_data = 5'(10 + i);
            cyc();
        end
        check("bp_full_level", level, 8);
        check("bp_full_ready", smp.s_ready, 0);
        cyc();
        check("bp_hold_level", level, 8);
        enable = 1'b1;
        cyc();
        check("bp_prime_ready", smp.s_ready, 0);
        check("bp_prime_playing", playing, 0);
        cyc();
        smp.s_valid = 1'b0;
        check("bp_pop_level", level, 7);
        check("bp_pop_ready", smp.s_ready, 1);
        check("bp_pop_ref", pwm_ref, 10);
        check("bp_pop_playing", playing, 1);

        // asynchronous reset between edges
        ticks(5);
        #2 reset = 1'b1;
        #1;
        check("arst_ref", pwm_ref, 0);
        check("arst_playing", playing, 0);
        check("arst_level", level, 0);
        check("arst_ur_cnt", underrun_cnt, 0);
        check("arst_ready", smp.s_ready, 1);
        check("arst_fs", frame_start, 0);
        cyc();
        reset = 1'b0; enable = 1'b0;
        cyc();
        check("post_rst_level", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/pwm_sample_sequencer.md
# pwm_sample_sequencer

Feeds 5-bit audio samples to the PWM audio output, one sample per PWM frame. Sits between the sample source (tone/ROM logic) and the PWM stage's `pwm_ref` input. It buffers incoming samples in a small FIFO with a valid/ready handshake and primes the buffer before playback. It then updates `pwm_ref` only at PWM frame boundaries, so a PWM period is never corrupted mid-frame, and reports underruns.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `PRIME_LEVEL`, 4: occupancy required before playback (re)starts; 1..DEPTH.
- `FRAME_TICKS`, 32: `tick` strobes per PWM frame; matches the 5-bit PWM counter period.
- `IDLE_LEVEL`, 5'd0: value driven on `pwm_ref` when not playing.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `enable`  in  1  playback enable (level).
- `tick`  in  1  one-cycle strobe, asserted each time the PWM counter advances.
- `s_data`  in  5  sample in.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  FIFO can accept a sample.
- `pwm_ref`  out  5  duty reference to the PWM stage.
- `frame_start`  out  1  one-cycle pulse when `pwm_ref` is (re)loaded at a frame boundary.
- `playing`  out  1  high in PLAY.
- `underrun`  out  1  one-cycle pulse when a frame boundary finds the FIFO empty.
- `underrun_cnt`  out  8  saturating underrun count.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **FIFO:**
  - Write when `s_valid && s_ready`.
  - `s_ready = (level < DEPTH)`, computed from the registered level. There is no same-cycle bypass: when full, `s_ready` = 0 even if a pop occurs that cycle.
  - A push and a pop in the same cycle leave `level` unchanged.
  - Pointers wrap modulo DEPTH.
- **FSM states:** IDLE, PRIME, PLAY.
- **IDLE:**
  - `pwm_ref` = IDLE_LEVEL, `frame_cnt` = 0, `playing` = 0.
  - The FIFO accepts writes.
  - Goes to PRIME when `enable` = 1.
- **PRIME:**
  - `pwm_ref` = IDLE_LEVEL, `frame_cnt` held at 0.
  - When `level >= PRIME_LEVEL`: go to PLAY, pop the head into `pwm_ref`, pulse `frame_start`, set `frame_cnt` = 0.
  - `enable` = 0 goes to IDLE.
- **PLAY:**
  - Each cycle with `tick` = 1: `frame_cnt++`.
  - When `tick` = 1 and `frame_cnt == FRAME_TICKS-1` (boundary): `frame_cnt` wraps to 0 and `frame_start` pulses.
    - If `level > 0`: pop the head into `pwm_ref`; stay in PLAY.
    - If `level == 0`: `pwm_ref` = IDLE_LEVEL, pulse `underrun`, `underrun_cnt++` (saturates at 255), go to PRIME.
  - `pwm_ref` never changes except at a boundary.
- **Disable:** `enable` = 0 in PRIME or PLAY causes:
  - next state IDLE, `pwm_ref` = IDLE_LEVEL;
  - FIFO flushed (`level` = 0), so stale audio is dropped.
  - A write attempted in that same cycle is discarded.
  - Disable has priority over a coincident boundary.
- `tick` is ignored outside PLAY.
- `underrun_cnt` clears only on `reset`.

## Timing
- All outputs are registered except `s_ready`, which is a registered-level compare.
- **Reset values:** state IDLE, `pwm_ref` = IDLE_LEVEL, `frame_start` = 0, `playing` = 0, `underrun` = 0, `underrun_cnt` = 0, `level` = 0, `s_ready` = 1.
- **Reset mid-operation:** outputs take their reset values immediately (asynchronous assertion). The FIFO contents are discarded.
- **Write → level:** `level` increments the cycle after an accepted write.
- **Prime latency:** `level` first reads ≥ PRIME_LEVEL in cycle N. Then in cycle N+1: state = PLAY, `pwm_ref` = sample, `frame_start` = 1, `playing` = 1.
- **Boundary latency:** boundary `tick` in cycle N gives new `pwm_ref` and the `frame_start` pulse in cycle N+1.
- **Frame length:** in steady PLAY, consecutive `frame_start` pulses are exactly FRAME_TICKS `tick` strobes apart.
- **Underrun:** `underrun` and `frame_start` pulse in the same cycle.

## Test plan
- **Basic playback:** reset, `enable`=1, write 4 samples 3,7,15,31, `tick` every 4 clocks → PLAY one cycle after `level`=4. `pwm_ref` reads 3, then 7/15/31 each after 32 ticks. `frame_start` pulses 4 times.
- **Underrun:** continue the previous test with no further writes → at the next boundary `pwm_ref`=0, `underrun` pulses once, `underrun_cnt`=1, state PRIME, `playing`=0. Writing 4 more samples restarts playback.
- **Backpressure:** DEPTH=8, hold `s_valid` with no ticks → `s_ready` drops after the 8th accept and `level`=8. A pop plus `s_valid` in the same cycle with full FIFO → no accept that cycle; `level`=7 next cycle, `s_ready`=1.
- **Simultaneous push/pop:** at a boundary with `level`=5 and an accepted write → `level` stays 5; the sample order is preserved.
- **Disable mid-frame:** drop `enable` at `frame_cnt`=10 with `level`=3 → next cycle IDLE, `pwm_ref`=0, `level`=0. Ticks are ignored afterwards.
- **Async reset mid-PLAY:** assert `reset` between clock edges → outputs go to reset values before the next edge. `underrun_cnt`=0; `s_ready`=1.
